// File: rtl/control_unit.sv
`timescale 1ns/1ps
// control_unit
// ------------
// Instruction sequencer for the 16-bit single-bus CPU. It fetches 23-bit
// instruction words from an asynchronous-read instruction memory and steps
// each instruction through a fixed multi-cycle sequence. In every cycle at
// most one source drives the bus and at most one register loads from it.
//
// Instruction word:
//   [22:20] ALU op, [19:18] class (00 MV, 01 MVI, 10 ALU, 11 HALT),
//   [5:3] Rx (destination), [2:0] Ry (source). MVI carries its 16-bit
//   immediate in bits [15:0] of the following word.
//
// Ports:
//   clk               in   1   system clock, rising edge
//   rst_n             in   1   asynchronous active-low reset
//   run               in   1   start request, honoured only in IDLE or DONE
//   instr             in   23  instruction memory data at `address`
//   address           out  6   program counter
//   code              out  23  instruction register (ALU op, immediate)
//   r_en_OH           out  10  register load enables: R0-R7, 8 = G, 9 = A
//   tri_controller_OH out  10  bus drivers: R0-R7, 8 = G, 9 = immediate
//   busy              out  1   high while an instruction sequence runs
//   done              out  1   high after HALT until the next run
module control_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [22:0] instr,
   output logic [5:0]  address,
   output logic [22:0] code,
   output logic [9:0]  r_en_OH,
   output logic [9:0]  tri_controller_OH,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_IMM,
      S_T1,
      S_T2,
      S_T3,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      C_MV   = 2'b00,
      C_MVI  = 2'b01,
      C_ALU  = 2'b10,
      C_HALT = 2'b11
   } class_t;

   // Bus / register slot numbers outside the general-purpose file.
   localparam logic [3:0] IDX_G   = 4'd8;
   localparam logic [3:0] IDX_A   = 4'd9;
   localparam logic [3:0] IDX_IMM = 4'd9;

   state_t     state;
   class_t     cls;
   logic [2:0] rx;
   logic [2:0] ry;

   function automatic logic [9:0] one_hot(input logic [3:0] idx);
      one_hot = 10'd1 << idx;
   endfunction

   // Single sequencer process. The enables and bus selects are registered:
   // on each edge we load the values that belong to the state being entered,
   // so they are glitch-free and clear asynchronously the moment reset
   // asserts, which also guarantees no register write after rst_n falls.
   // The instruction class is kept in its own latch because IR is
   // overwritten by the immediate word of an MVI before T1 runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         cls               <= C_MV;
         rx                <= 3'd0;
         ry                <= 3'd0;
         address           <= 6'd0;
         code              <= 23'd0;
         r_en_OH           <= 10'd0;
         tri_controller_OH <= 10'd0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         r_en_OH           <= 10'd0;
         tri_controller_OH <= 10'd0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (run) begin
                  address <= 6'd0;
                  state   <= S_FETCH;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            S_FETCH: begin
               code    <= instr;
               rx      <= instr[5:3];
               ry      <= instr[2:0];
               cls     <= class_t'(instr[19:18]);
               address <= address + 6'd1;
               unique case (class_t'(instr[19:18]))
                  C_MV: begin
                     state             <= S_T1;
                     tri_controller_OH <= one_hot({1'b0, instr[2:0]});
                     r_en_OH           <= one_hot({1'b0, instr[5:3]});
                  end
                  C_MVI: begin
                     state <= S_IMM;
                  end
                  C_ALU: begin
                     state             <= S_T1;
                     tri_controller_OH <= one_hot({1'b0, instr[5:3]});
                     r_en_OH           <= one_hot(IDX_A);
                  end
                  C_HALT: begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
                  default: state <= S_IDLE;
               endcase
            end
            S_IMM: begin
               code              <= instr;
               address           <= address + 6'd1;
               state             <= S_T1;
               tri_controller_OH <= one_hot(IDX_IMM);
               r_en_OH           <= one_hot({1'b0, rx});
            end
            S_T1: begin
               // Only ALU instructions continue past T1.
               if (cls == C_ALU) begin
                  state             <= S_T2;
                  tri_controller_OH <= one_hot({1'b0, ry});
                  r_en_OH           <= one_hot(IDX_G);
               end else begin
                  state <= S_FETCH;
               end
            end
            S_T2: begin
               state             <= S_T3;
               tri_controller_OH <= one_hot(IDX_G);
               r_en_OH           <= one_hot({1'b0, rx});
            end
            S_T3: begin
               state <= S_FETCH;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
// tb_control_unit
// ---------------
// Directed bench for control_unit. It owns the instruction memory and a
// small behavioural datapath (R0-R7, G, A, shared bus) driven by the
// sequencer's enables, so register results can be checked end to end.
// Each scenario task drives its own program and compares at negedge.
module tb_control_unit;

   localparam logic [1:0] CLS_MV   = 2'b00;
   localparam logic [1:0] CLS_MVI  = 2'b01;
   localparam logic [1:0] CLS_ALU  = 2'b10;
   localparam logic [1:0] CLS_HALT = 2'b11;
   localparam logic [2:0] OP_ADD   = 3'b001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [22:0] instr;
   logic [5:0]  address;
   logic [22:0] code;
   logic [9:0]  r_en_OH;
   logic [9:0]  tri_controller_OH;
   logic        busy;
   logic        done;

   logic [22:0] imem [0:63];
   logic [15:0] rf [0:9];
   logic [15:0] bus;

   int checks = 0;
   int errors = 0;

   control_unit dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .run               (run),
      .instr             (instr),
      .address           (address),
      .code              (code),
      .r_en_OH           (r_en_OH),
      .tri_controller_OH (tri_controller_OH),
      .busy              (busy),
      .done              (done)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Asynchronous-read instruction memory.
   assign instr = imem[address];

   function automatic logic [22:0] enc(input logic [2:0] op, input logic [1:0] cls,
                                       input logic [2:0] rx, input logic [2:0] ry);
      return {op, cls, 12'd0, rx, ry};
   endfunction

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op);
      return (op == OP_ADD) ? a + b : a - b;
   endfunction

   // Bus model: whichever source is selected drives it, immediate from code.
   always_comb begin
      bus = 16'd0;
      for (int i = 0; i < 9; i++)
         if (tri_controller_OH[i]) bus = rf[i];
      if (tri_controller_OH[9]) bus = code[15:0];
   end

   // Register file model: loads land on the edge ending the enable cycle;
   // G captures the ALU result of A and the bus.
   always @(posedge clk) begin
      for (int i = 0; i < 10; i++)
         if (r_en_OH[i]) rf[i] <= (i == 8) ? alu_model(rf[9], bus, code[22:20]) : bus;
   end

   // One-hot-or-zero invariant on both vectors, every cycle.
   always @(negedge clk) begin
      checks++;
      if ($countones(tri_controller_OH) > 1 || $countones(r_en_OH) > 1) begin
         errors++;
         $display("[TB] FAIL onehot: tri=%h r_en=%h required at most one bit each",
                  tri_controller_OH, r_en_OH);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic clear_mem;
      for (int i = 0; i < 64; i++) imem[i] = 23'd0;
   endtask

   // Called at a negedge; returns at the negedge of the first FETCH cycle.
   task automatic pulse_run;
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic load_alu_program(input logic [15:0] a_val, input logic [15:0] b_val);
      clear_mem();
      imem[0] = enc(3'd0, CLS_MVI, 3'd2, 3'd0);
      imem[1] = {7'd0, a_val};
      imem[2] = enc(3'd0, CLS_MVI, 3'd4, 3'd0);
      imem[3] = {7'd0, b_val};
      imem[4] = enc(OP_ADD, CLS_ALU, 3'd2, 3'd4);
      imem[5] = enc(3'd0, CLS_HALT, 3'd0, 3'd0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      run   = 1'b0;
      clear_mem();
      #3;
      checks++;
      if ({address, code, r_en_OH, tri_controller_OH, busy, done} !== 43'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got addr=%h code=%h r_en=%h tri=%h busy=%b done=%b required all 0",
                  address, code, r_en_OH, tri_controller_OH, busy, done);
      end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if ({address, busy, done} !== 8'd0) begin
         errors++;
         $display("[TB] FAIL idle_hold: got addr=%h busy=%b done=%b required 0 0 0", address, busy, done);
      end
   endtask

   task automatic test_mvi_halt;
      clear_mem();
      imem[0] = enc(3'd0, CLS_MVI, 3'd3, 3'd0);
      imem[1] = 23'h00A55A;
      imem[2] = enc(3'd0, CLS_HALT, 3'd0, 3'd0);
      pulse_run();
      checks++;
      if ({address, busy, r_en_OH, tri_controller_OH} !== {6'd0, 1'b1, 20'd0}) begin
         errors++;
         $display("[TB] FAIL mvi_fetch: got addr=%h busy=%b r_en=%h tri=%h required 00 1 000 000",
                  address, busy, r_en_OH, tri_controller_OH);
      end
      tick();
      checks++;
      if ({address, code, r_en_OH, tri_controller_OH} !== {6'd1, enc(3'd0, CLS_MVI, 3'd3, 3'd0), 20'd0}) begin
         errors++;
         $display("[TB] FAIL mvi_imm: got addr=%h code=%h r_en=%h tri=%h required 01 %h 000 000",
                  address, code, r_en_OH, tri_controller_OH, enc(3'd0, CLS_MVI, 3'd3, 3'd0));
      end
      tick();
      checks++;
      if ({tri_controller_OH, r_en_OH, code} !== {10'h200, 10'h008, 23'h00A55A}) begin
         errors++;
         $display("[TB] FAIL mvi_t1: got tri=%h r_en=%h code=%h required 200 008 00a55a",
                  tri_controller_OH, r_en_OH, code);
      end
      tick();
      checks++;
      if (rf[3] !== 16'hA55A) begin
         errors++;
         $display("[TB] FAIL mvi_r3: got %h required a55a", rf[3]);
      end
      tick();
      checks++;
      if ({done, busy, address} !== {1'b1, 1'b0, 6'd3}) begin
         errors++;
         $display("[TB] FAIL mvi_done: got done=%b busy=%b addr=%h required 1 0 03", done, busy, address);
      end
      tick();
      checks++;
      if ({done, address} !== {1'b1, 6'd3}) begin
         errors++;
         $display("[TB] FAIL done_hold: got done=%b addr=%h required 1 03", done, address);
      end
   endtask

   task automatic test_mv;
      clear_mem();
      imem[0] = enc(3'd0, CLS_MVI, 3'd1, 3'd0);
      imem[1] = 23'h001234;
      imem[2] = enc(3'd0, CLS_MV, 3'd6, 3'd1);
      imem[3] = enc(3'd0, CLS_HALT, 3'd0, 3'd0);
      pulse_run();
      checks++;
      if ({done, busy, address} !== {1'b0, 1'b1, 6'd0}) begin
         errors++;
         $display("[TB] FAIL restart_from_done: got done=%b busy=%b addr=%h required 0 1 00", done, busy, address);
      end
      repeat (3) tick();
      tick();
      checks++;
      if ({tri_controller_OH, r_en_OH} !== {10'h002, 10'h040}) begin
         errors++;
         $display("[TB] FAIL mv_t1: got tri=%h r_en=%h required 002 040", tri_controller_OH, r_en_OH);
      end
      tick();
      checks++;
      if (rf[6] !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL mv_r6: got %h required 1234", rf[6]);
      end
      tick();
      checks++;
      if ({done, address} !== {1'b1, 6'd4}) begin
         errors++;
         $display("[TB] FAIL mv_done: got done=%b addr=%h required 1 04", done, address);
      end
   endtask

   task automatic test_alu;
      load_alu_program(16'd5, 16'd7);
      pulse_run();
      repeat (6) tick();
      checks++;
      if (address !== 6'd4) begin
         errors++;
         $display("[TB] FAIL alu_fetch_addr: got %h required 04", address);
      end
      tick();
      checks++;
      if ({tri_controller_OH, r_en_OH} !== {10'h004, 10'h200}) begin
         errors++;
         $display("[TB] FAIL alu_t1: got tri=%h r_en=%h required 004 200", tri_controller_OH, r_en_OH);
      end
      tick();
      checks++;
      if ({tri_controller_OH, r_en_OH, code[22:20]} !== {10'h010, 10'h100, OP_ADD}) begin
         errors++;
         $display("[TB] FAIL alu_t2: got tri=%h r_en=%h op=%h required 010 100 %h",
                  tri_controller_OH, r_en_OH, code[22:20], OP_ADD);
      end
      tick();
      checks++;
      if ({tri_controller_OH, r_en_OH, code} !== {10'h100, 10'h004, enc(OP_ADD, CLS_ALU, 3'd2, 3'd4)}) begin
         errors++;
         $display("[TB] FAIL alu_t3: got tri=%h r_en=%h code=%h required 100 004 %h",
                  tri_controller_OH, r_en_OH, code, enc(OP_ADD, CLS_ALU, 3'd2, 3'd4));
      end
      tick();
      checks++;
      if (rf[2] !== 16'd12) begin
         errors++;
         $display("[TB] FAIL alu_r2: got %h required 000c", rf[2]);
      end
      tick();
      checks++;
      if ({done, address} !== {1'b1, 6'd6}) begin
         errors++;
         $display("[TB] FAIL alu_done: got done=%b addr=%h required 1 06", done, address);
      end
   endtask

   task automatic test_run_while_busy;
      load_alu_program(16'd5, 16'd7);
      pulse_run();
      repeat (6) tick();
      tick();
      tick();
      run = 1'b1;
      tick();
      run = 1'b0;
      checks++;
      if ({tri_controller_OH, r_en_OH, address, busy} !== {10'h100, 10'h004, 6'd5, 1'b1}) begin
         errors++;
         $display("[TB] FAIL busy_run_t3: got tri=%h r_en=%h addr=%h busy=%b required 100 004 05 1",
                  tri_controller_OH, r_en_OH, address, busy);
      end
      tick();
      checks++;
      if ({rf[2], address} !== {16'd12, 6'd5}) begin
         errors++;
         $display("[TB] FAIL busy_run_result: got r2=%h addr=%h required 000c 05", rf[2], address);
      end
      tick();
      checks++;
      if ({done, address} !== {1'b1, 6'd6}) begin
         errors++;
         $display("[TB] FAIL busy_run_done: got done=%b addr=%h required 1 06", done, address);
      end
   endtask

   task automatic test_pc_wrap;
      bit found;
      clear_mem();
      // Word 0 runs first as MV R0,R0 and later serves as the MVI immediate.
      imem[0]  = 23'h001240;
      imem[63] = enc(3'd0, CLS_MVI, 3'd5, 3'd0);
      pulse_run();
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (address == 6'd63 && r_en_OH == 10'd0) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL wrap_reach63: got addr=%h required fetch at 3f within 300 cycles", address);
      end
      imem[1] = enc(3'd0, CLS_HALT, 3'd0, 3'd0);
      tick();
      checks++;
      if ({address, code} !== {6'd0, enc(3'd0, CLS_MVI, 3'd5, 3'd0)}) begin
         errors++;
         $display("[TB] FAIL wrap_imm: got addr=%h code=%h required 00 %h",
                  address, code, enc(3'd0, CLS_MVI, 3'd5, 3'd0));
      end
      tick();
      checks++;
      if ({address, code, tri_controller_OH, r_en_OH} !== {6'd1, 23'h001240, 10'h200, 10'h020}) begin
         errors++;
         $display("[TB] FAIL wrap_t1: got addr=%h code=%h tri=%h r_en=%h required 01 001240 200 020",
                  address, code, tri_controller_OH, r_en_OH);
      end
      tick();
      checks++;
      if (rf[5] !== 16'h1240) begin
         errors++;
         $display("[TB] FAIL wrap_r5: got %h required 1240", rf[5]);
      end
      tick();
      checks++;
      if ({done, address} !== {1'b1, 6'd2}) begin
         errors++;
         $display("[TB] FAIL wrap_done: got done=%b addr=%h required 1 02", done, address);
      end
   endtask

   task automatic test_reset_mid_instruction;
      logic [15:0] g_before;
      load_alu_program(16'd9, 16'd4);
      pulse_run();
      repeat (6) tick();
      tick();
      tick();
      checks++;
      if (r_en_OH !== 10'h100) begin
         errors++;
         $display("[TB] FAIL midreset_in_t2: got r_en=%h required 100", r_en_OH);
      end
      g_before = rf[8];
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({address, code, r_en_OH, tri_controller_OH, busy, done} !== 43'd0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got addr=%h code=%h r_en=%h tri=%h busy=%b done=%b required all 0",
                  address, code, r_en_OH, tri_controller_OH, busy, done);
      end
      tick();
      checks++;
      if ({rf[8], rf[2]} !== {g_before, 16'd9}) begin
         errors++;
         $display("[TB] FAIL midreset_no_write: got g=%h r2=%h required %h 0009", rf[8], rf[2], g_before);
      end
      rst_n = 1'b1;
      run   = 1'b0;
      repeat (10) tick();
      checks++;
      if ({address, code, busy, done} !== 31'd0) begin
         errors++;
         $display("[TB] FAIL midreset_idle: got addr=%h code=%h busy=%b done=%b required 00 000000 0 0",
                  address, code, busy, done);
      end
   endtask

   // Scenario sequence; each test leaves the sequencer in IDLE or DONE.
   initial begin
      $display("[TB] control_unit directed tests starting");
      test_reset();
      test_mvi_halt();
      test_mv();
      test_alu();
      test_run_while_busy();
      test_pc_wrap();
      test_reset_mid_instruction();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
